// File: rtl/register_file.sv
// 32-entry MIPS register file: two combinational read ports, one clocked write port.
// Entry 0 has no storage and always reads zero; same-cycle read-through is optional.
module register_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit WRITE_BYPASS = 1'b0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] store [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] view  [DEPTH];
  logic                  wr_active;

  assign wr_active = ResetN && RegWrite && (WriteReg != '0);

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
        store[i] <= '0;
      end else if (wr_active && (WriteReg == ADDR_WIDTH'(i))) begin
        store[i] <= WriteData;
      end
    end
  end

  // Full-depth view with a constant zero at index 0 keeps the read mux in range.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = store[i];
    end
  end

  always_comb begin
    ReadData1 = view[ReadReg1];
    ReadData2 = view[ReadReg2];
    if (WRITE_BYPASS) begin
      if (wr_active && (WriteReg == ReadReg1)) ReadData1 = WriteData;
      if (wr_active && (WriteReg == ReadReg2)) ReadData2 = WriteData;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; one instance without bypass, one with bypass,
// both driven by the same stimulus.
module tb_register_file;

  logic        Clock = 1'b0;
  logic        clk_en = 1'b0;
  logic        ResetN;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] rd1_nb, rd2_nb, rd1_b, rd2_b;

  int total = 0;
  int bad   = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b0)) dut_nb (
    .Clock(Clock), .ResetN(ResetN), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b1)) dut_b (
    .Clock(Clock), .ResetN(ResetN), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  always begin
    #5;
    if (clk_en) Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write(input logic [4:0] idx, input logic [31:0] val);
    RegWrite  = 1'b1;
    WriteReg  = idx;
    WriteData = val;
    tick();
    RegWrite  = 1'b0;
  endtask

  initial begin
    ResetN = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // reset with no clock running
    #3 ResetN = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      check($sformatf("rst_nb_rd1[%0d]", i), rd1_nb, 32'h0);
      check($sformatf("rst_b_rd1[%0d]", i), rd1_b, 32'h0);
      check($sformatf("rst_nb_rd2[%0d]", 31 - i), rd2_nb, 32'h0);
    end
    #1 ResetN = 1'b1;
    #1 clk_en = 1'b1;

    // basic write
    write(5'd8, 32'hDEADBEEF);
    write(5'd9, 32'h00000005);
    ReadReg1 = 5'd8; ReadReg2 = 5'd9;
    #1;
    check("basic_nb_rd1", rd1_nb, 32'hDEADBEEF);
    check("basic_nb_rd2", rd2_nb, 32'h00000005);
    check("basic_b_rd1",  rd1_b,  32'hDEADBEEF);
    check("basic_b_rd2",  rd2_b,  32'h00000005);

    // $0 protection, pending and after the edge
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1;
    check("zero_pend_nb", rd1_nb, 32'h0);
    check("zero_pend_b1", rd1_b,  32'h0);
    check("zero_pend_b2", rd2_b,  32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("zero_after_nb", rd1_nb, 32'h0);
    check("zero_after_b",  rd1_b,  32'h0);

    // collision
    write(5'd8, 32'h11111111);
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h22222222;
    ReadReg1 = 5'd8; ReadReg2 = 5'd9;
    #1;
    check("coll_pre_nb",  rd1_nb, 32'h11111111);
    check("coll_pre_b",   rd1_b,  32'h22222222);
    check("coll_pre_b2",  rd2_b,  32'h00000005);
    tick();
    RegWrite = 1'b0;
    #1;
    check("coll_post_nb", rd1_nb, 32'h22222222);
    check("coll_post_b",  rd1_b,  32'h22222222);

    // both ports on the same register
    ReadReg2 = 5'd8;
    #1;
    check("same_reg_nb2", rd2_nb, 32'h22222222);

    // write enable off
    RegWrite = 1'b0; WriteReg = 5'd8; WriteData = 32'hABCD0000;
    #1;
    check("wen_off_pend_b", rd1_b, 32'h22222222);
    tick();
    check("wen_off_nb", rd1_nb, 32'h22222222);
    check("wen_off_b",  rd1_b,  32'h22222222);

    // reset mid-run
    for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
    ReadReg1 = 5'd31; ReadReg2 = 5'd17;
    #1;
    check("load_nb_31", rd1_nb, 32'd31);
    check("load_b_17",  rd2_b,  32'd17);
    #1 ResetN = 1'b0;
    #1 ResetN = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(i);
      #0.1;
      check($sformatf("midrst_nb[%0d]", i), rd1_nb, 32'h0);
      check($sformatf("midrst_b[%0d]", i),  rd2_b,  32'h0);
    end
    write(5'd3, 32'd7);
    ReadReg1 = 5'd3; ReadReg2 = 5'd4;
    #1;
    check("post_rst_nb_3", rd1_nb, 32'd7);
    check("post_rst_b_3",  rd1_b,  32'd7);
    check("post_rst_nb_4", rd2_nb, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
